inst_fetch_unit: RTL
====================

# inst_fetch_unit

Program-counter and instruction-memory front end that sits directly upstream of the decode stage. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures the returned word together with its PC into a one-entry output buffer. It then presents that entry to the decode stage over a valid/ready handshake. Control-flow redirects from the execute stage override the PC at any time and squash any in-flight or buffered fetch.

## Interface
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset (XLEN bits)

- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address (= PC)
- imem_resp_valid  in  1  response word valid
- imem_resp_data  in  ILEN  returned instruction word
- imem_resp_fault  in  1  access fault on this response
- redirect_valid  in  1  PC override from execute (branch/jump taken)
- redirect_pc  in  XLEN  new PC
- inst_valid  out  1  buffered instruction available to decode
- inst_ready  in  1  decode consumes buffer this cycle
- inst  out  ILEN  instruction word to decode
- inst_pc  out  XLEN  PC of `inst`
- inst_fault  out  1  fetch faulted (access fault or misaligned PC); `inst` is 0

## Operation
- States: BOOT, REQ, WAIT, DROP, OUT. Reset enters BOOT. BOOT moves to REQ unconditionally on the next edge.
- Only one request may be outstanding. Memory returns exactly one response per accepted request, in order, with no flow control on responses.
- Redirect has priority over every other event in every state. It always loads `pc <= redirect_pc` and clears the buffer.
  - If `redirect_pc[1:0] != 0` in a state with no outstanding request, go to OUT with `inst_fault=1`, `inst=0`, `inst_pc=redirect_pc`. No memory request is issued.
- REQ: `imem_req_valid=1`, `imem_req_addr=pc`.
  - Handshake without redirect → WAIT.
  - Handshake with redirect → DROP.
  - Redirect without handshake → REQ with the new address. The address changes only in this case.
- WAIT: on `imem_resp_valid` without redirect, capture the buffer as `inst` = data (or 0 if fault), `inst_pc=pc`, `inst_fault=imem_resp_fault`. Then `pc <= pc + 4`, go to OUT.
  - Redirect with `resp_valid` in the same cycle: the response is discarded; go to REQ (or to OUT on misaligned).
  - Redirect without `resp_valid`: go to DROP.
- DROP: wait for the stale response and discard it, then go to REQ. Further redirects only update `pc`. A misaligned `pc` at DROP exit goes to OUT with a fault instead of REQ.
- OUT: `inst_valid=1`, buffer held stable. `inst_ready` → REQ. On a fault the PC is not advanced, and decode/execute must redirect.
- PC arithmetic: `pc + 4` modulo 2^XLEN. `0xFFFF_FFFC` wraps to 0.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_fault=0`, `pc=RESET_PC`.
- First request is asserted in the first cycle after BOOT, i.e. the 2nd edge after reset release.
- Zero-wait memory: the request is accepted at cycle t, the response arrives at t+1, `inst_valid` rises at t+2. Throughput is 1 instruction per 3 cycles.
- Redirect at cycle t, no outstanding request: `imem_req_addr=redirect_pc` from t+1.
- Redirect and `inst_ready` in the same cycle in OUT: redirect wins and the buffer is cleared, so the old entry is treated as consumed.
- `inst`, `inst_pc`, `inst_fault` are registered and change only on capture, redirect or reset.
- `inst_valid` and `imem_req_valid` are decoded from the state register only, with no input-to-output combinational path.
- Reset asserted mid-transaction: immediate return to reset values. A memory response arriving after reset is ignored (state BOOT/REQ).

## Structure
- Package `fetch_pkg`: state enum `fetch_state_e` {BOOT, REQ, WAIT, DROP, OUT}, constant `PC_STEP = 4`, helper function for the misalignment check.
- Sub-module `inst_buffer`: one-entry register holding {inst, inst_pc, inst_fault}, with load and clear controls.
- Top level holds the state register, the PC register and the next-state logic.

## Test plan
- Reset with RESET_PC=0x100 and a zero-wait memory returning 0x00500093 → `imem_req_addr=0x100` at cycle 2; `inst=0x00500093`, `inst_pc=0x100` with `inst_valid` at cycle 4; next request to 0x104.
- Hold `inst_ready=0` for 5 cycles in OUT → `inst`, `inst_pc` and `inst_valid` stable; no new request issued; on release, request to pc+4.
- Redirect to 0x200 in WAIT while the response is 2 cycles late → DROP; the late response is discarded; next request to 0x200; the discarded word never reaches `inst`.
- `imem_resp_fault=1` at 0x300 → `inst_valid=1`, `inst_fault=1`, `inst=0`, `inst_pc=0x300`; `pc` stays 0x300.
- Redirect to 0x202 (misaligned) in OUT → no memory request; `inst_fault=1`, `inst_pc=0x202` next cycle.
- PC at 0xFFFFFFFC fetches successfully → next request address 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, PC step and alignment helper for the fetch front end
package fetch_pkg;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, OUT} fetch_state_e;
  localparam int PC_STEP = 4;
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/inst_fetch_unit_buffer.sv
// inst_buffer: one-entry {inst, inst_pc, inst_fault} register; load wins over clear
// ports: clk, rst_n, load/clear controls, d_* entry to load, q_* held entry
module inst_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] d_inst,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_fault,
  output logic [ILEN-1:0] q_inst,
  output logic [XLEN-1:0] q_pc,
  output logic            q_fault
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q_inst, q_pc, q_fault} <= '0;
    else if (load) {q_inst, q_pc, q_fault} <= {d_inst, d_pc, d_fault};
    else if (clear) {q_inst, q_pc, q_fault} <= '0;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner issuing one imem request at a time and buffering the result for decode
// ports: imem_req_* request channel, imem_resp_* response, redirect_* from execute, inst_* to decode
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            imem_resp_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);
  fetch_state_e state, nxt;
  logic [XLEN-1:0] pc, pc_nxt, ld_pc;
  logic [ILEN-1:0] ld_inst;
  logic load, clear, ld_fault, rd_bad;
  assign rd_bad = misaligned(redirect_pc[1:0]);
  // A misaligned target never reaches memory: it is loaded as a fault entry instead.
  always_comb begin
    nxt = state;
    pc_nxt = redirect_valid ? redirect_pc : pc;
    ld_pc = pc_nxt;
    ld_inst = '0;
    ld_fault = 1'b1;
    clear = redirect_valid;
    load = 1'b0;
    case (state)
      BOOT: begin
        nxt = redirect_valid && rd_bad ? OUT : REQ;
        load = redirect_valid && rd_bad;
      end
      REQ:
        if (redirect_valid) begin
          nxt = imem_req_ready ? DROP : (rd_bad ? OUT : REQ);
          load = !imem_req_ready && rd_bad;
        end else if (imem_req_ready) nxt = WAIT;
      WAIT:
        if (redirect_valid) begin
          nxt = imem_resp_valid ? (rd_bad ? OUT : REQ) : DROP;
          load = imem_resp_valid && rd_bad;
        end else if (imem_resp_valid) begin
          nxt = OUT;
          load = 1'b1;
          ld_inst = imem_resp_fault ? '0 : imem_resp_data;
          ld_fault = imem_resp_fault;
          pc_nxt = imem_resp_fault ? pc : pc + XLEN'(PC_STEP);
        end
      // The stale response is swallowed; the exit decision uses the latest PC.
      DROP:
        if (imem_resp_valid) begin
          nxt = misaligned(pc_nxt[1:0]) ? OUT : REQ;
          load = misaligned(pc_nxt[1:0]);
        end
      OUT:
        if (redirect_valid) begin
          nxt = rd_bad ? OUT : REQ;
          load = rd_bad;
        end else if (inst_ready) nxt = REQ;
      default: nxt = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
    end else begin
      state <= nxt;
      pc <= pc_nxt;
    end
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
  assign inst_valid = state == OUT;
  inst_buffer #(.XLEN(XLEN), .ILEN(ILEN)) u_buf (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(clear),
    .d_inst(ld_inst), .d_pc(ld_pc), .d_fault(ld_fault),
    .q_inst(inst), .q_pc(inst_pc), .q_fault(inst_fault)
  );
endmodule
